// File: rtl/buffer_fpga_to_hps.sv
// rtl/buffer_fpga_to_hps.sv - captures a 5x5 result matrix, compacts the NxN block and streams it as 32-bit words
module buffer_fpga_to_hps #(
    parameter int ELEM_W  = 8,
    parameter int DIM_MAX = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load,
    input  logic [1:0]                          size,
    input  logic [DIM_MAX*DIM_MAX*ELEM_W-1:0]   matrix_in,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [31:0]                         out_data,
    output logic                                out_last,
    output logic [2:0]                          out_index,
    output logic                                busy,
    output logic                                done
);

    localparam int MAT_W    = DIM_MAX * DIM_MAX * ELEM_W;
    localparam int NWORDS   = 7;
    localparam int PACKED_W = NWORDS * 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] words [NWORDS];
    logic [2:0]  idx;
    logic [2:0]  last_idx;

    logic [PACKED_W-1:0] packed_vec;
    logic [2:0]          last_idx_next;

    // Byte k of the dense stream is element (k/N, k%N); the tail of the last word stays zero.
    function automatic logic [PACKED_W-1:0] compact(input logic [MAT_W-1:0] m, input int n);
        logic [PACKED_W-1:0] v;
        v = '0;
        for (int r = 0; r < DIM_MAX; r++) begin
            for (int c = 0; c < DIM_MAX; c++) begin
                if (r < n && c < n) begin
                    v[PACKED_W-1-ELEM_W*(r*n+c) -: ELEM_W] = m[MAT_W-1-ELEM_W*(DIM_MAX*r+c) -: ELEM_W];
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        packed_vec    = '0;
        last_idx_next = 3'd0;
        case (size)
            2'b00: begin
                packed_vec    = compact(matrix_in, 2);
                last_idx_next = 3'd0;
            end
            2'b01: begin
                packed_vec    = compact(matrix_in, 3);
                last_idx_next = 3'd2;
            end
            2'b10: begin
                packed_vec    = compact(matrix_in, 4);
                last_idx_next = 3'd3;
            end
            default: begin
                packed_vec    = compact(matrix_in, 5);
                last_idx_next = 3'd6;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 3'd0;
            last_idx <= 3'd0;
            for (int i = 0; i < NWORDS; i++) begin
                words[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            words[i] <= packed_vec[PACKED_W-1-32*i -: 32];
                        end
                        last_idx <= last_idx_next;
                        idx      <= 3'd0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    // load is deliberately not looked at here, so the captured matrix cannot be disturbed.
                    if (out_ready) begin
                        if (idx == last_idx) begin
                            idx   <= 3'd0;
                            state <= DONE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_index = out_valid ? idx : 3'd0;
    assign out_data  = out_valid ? words[idx] : 32'd0;
    assign out_last  = out_valid && (idx == last_idx);

endmodule

// File: tb/tb_buffer_fpga_to_hps.sv
// tb/tb_buffer_fpga_to_hps.sv - directed self-checking bench for buffer_fpga_to_hps
module tb_buffer_fpga_to_hps;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [1:0]   size;
    logic [199:0] matrix_in;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic [2:0]   out_index;
    logic         busy;
    logic         done;

    int tests_run;
    int tests_failed;

    buffer_fpga_to_hps #(.ELEM_W(8), .DIM_MAX(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .size      (size),
        .matrix_in (matrix_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] mat_seq();
        logic [199:0] m;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[199-8*(5*r+c) -: 8] = 8'(5*r + c + 1);
        return m;
    endfunction

    function automatic logic [199:0] mat_fill(input int n);
        logic [199:0] m;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[199-8*(5*r+c) -: 8] = (r < n && c < n) ? 8'(16*r + c) : 8'hFF;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [199:0] m, input logic [1:0] sz);
        matrix_in = m;
        size      = sz;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        matrix_in = {200{1'b1}};
        size      = 2'b11;
    endtask

    // Walks a stream; bp selects the fixed stall pattern, load_at injects a competing load.
    task automatic run_stream(input string name, input logic [31:0] exp [7], input int w,
                              input bit bp, input int load_at);
        logic [15:0] pat;
        logic [31:0] hd;
        logic [2:0]  hi;
        logic        hl;
        bit          stalled;
        int          got;
        int          cyc;
        int          dones;
        pat = 16'b1011_0010_1100_1101;
        stalled = 1'b0;
        got = 0;
        cyc = 0;
        dones = 0;
        while (got < w && cyc < 200) begin
            out_ready = bp ? pat[cyc % 16] : 1'b1;
            if (cyc == load_at) begin
                load      = 1'b1;
                matrix_in = mat_fill(2);
                size      = 2'b00;
            end else begin
                load = 1'b0;
            end
            if (done) dones++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                check({name, " valid/busy"}, {30'd0, out_valid, busy}, 32'd3);
            end
            if (stalled) begin
                check({name, " hold data"}, out_data, hd);
                check({name, " hold idx/last"}, {28'd0, out_index, hl}, {28'd0, hi, hl});
                if (out_last !== hl) check({name, " hold last"}, {31'd0, out_last}, {31'd0, hl});
            end
            if (out_ready) begin
                check({name, " data"}, out_data, exp[got]);
                check({name, " index"}, {29'd0, out_index}, 32'(got));
                check({name, " last"}, {31'd0, out_last}, {31'd0, got == w - 1});
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hd = out_data;
                hi = out_index;
                hl = out_last;
            end
            tick();
            cyc++;
        end
        load      = 1'b0;
        out_ready = 1'b1;
        check({name, " transfers"}, 32'(got), 32'(w));
        check({name, " done pulse"}, {30'd0, done, out_valid}, 32'd2);
        check({name, " done data"}, out_data, 32'd0);
        check({name, " no early done"}, 32'(dones), 32'd0);
        tick();
        check({name, " idle after done"}, {30'd0, done, busy}, 32'd0);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, " outputs"}, {25'd0, out_valid, out_last, out_index, busy, done}, 32'd0);
        check({name, " data"}, out_data, 32'd0);
    endtask

    task automatic test_reset();
        check_zero_outputs("reset");
    endtask

    task automatic test_5x5();
        logic [31:0] e [7];
        e = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
              32'h11121314, 32'h15161718, 32'h19000000};
        do_load(mat_seq(), 2'b11);
        run_stream("5x5", e, 7, 1'b0, -1);
    endtask

    task automatic test_3x3();
        logic [31:0] e [7];
        e = '{32'h00010210, 32'h11122021, 32'h22000000, 0, 0, 0, 0};
        do_load(mat_fill(3), 2'b01);
        run_stream("3x3", e, 3, 1'b0, -1);
    endtask

    task automatic test_2x2();
        logic [31:0] e [7];
        e = '{32'h00011011, 0, 0, 0, 0, 0, 0};
        do_load(mat_fill(2), 2'b00);
        run_stream("2x2", e, 1, 1'b0, -1);
    endtask

    task automatic test_4x4();
        logic [31:0] e [7];
        e = '{32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233, 0, 0, 0};
        do_load(mat_fill(4), 2'b10);
        run_stream("4x4", e, 4, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        logic [31:0] e [7];
        e = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
              32'h11121314, 32'h15161718, 32'h19000000};
        do_load(mat_seq(), 2'b11);
        run_stream("backpressure", e, 7, 1'b1, -1);
    endtask

    task automatic test_load_while_busy();
        logic [31:0] e [7];
        e = '{32'h00010210, 32'h11122021, 32'h22000000, 0, 0, 0, 0};
        do_load(mat_fill(3), 2'b01);
        run_stream("load_busy", e, 3, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] e [7];
        e = '{32'h00011011, 0, 0, 0, 0, 0, 0};
        // Load held through DONE must be ignored there and accepted once back in IDLE.
        do_load(mat_fill(2), 2'b00);
        out_ready = 1'b1;
        tick();
        load      = 1'b1;
        matrix_in = mat_fill(2);
        size      = 2'b00;
        check("b2b done", {31'd0, done}, 32'd1);
        tick();
        check("b2b idle", {31'd0, busy}, 32'd0);
        tick();
        load      = 1'b0;
        check("b2b reload valid", {31'd0, out_valid}, 32'd1);
        run_stream("b2b", e, 1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] e [7];
        e = '{32'h00011011, 0, 0, 0, 0, 0, 0};
        do_load(mat_seq(), 2'b11);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("mid idx", {29'd0, out_index}, 32'd3);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid reset async");
        tick();
        check_zero_outputs("mid reset held");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_zero_outputs("after release");
        out_ready = 1'b1;
        do_load(mat_fill(2), 2'b00);
        run_stream("post reset 2x2", e, 1, 1'b0, -1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        load      = 1'b0;
        size      = 2'b00;
        matrix_in = '0;
        out_ready = 1'b0;
        tick();
        tick();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_5x5();
        test_3x3();
        test_2x2();
        test_4x4();
        test_backpressure();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/buffer_fpga_to_hps.md
# buffer_fpga_to_hps

- Return-path buffer between the matrix coprocessor core and the HPS bridge.
- Captures a 200-bit result matrix in the core's fixed 5x5 layout.
- Compacts the active NxN sub-matrix (N = 2..5) into a dense row-major byte stream.
- Transmits the stream to the HPS as 32-bit words over a valid/ready handshake, with last-word and done indications.

## Interface
- ELEM_W, 8: element width in bits; only 8 is supported.
- DIM_MAX, 5: layout dimension; matrix width = DIM_MAX*DIM_MAX*ELEM_W = 200; only 5 is supported.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  capture request; sampled only in IDLE.
- size  in  2  matrix size code: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- matrix_in  in  200  result matrix in 5x5 layout.
- out_ready  in  1  HPS-side consumer ready.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  32  packed output word.
- out_last  out  1  current word is the final word of the matrix.
- out_index  out  3  index of the current word (0..6).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the final word transfers.

## Operation
- **5x5 layout:** element (r,c) occupies matrix_in[199-8*(5r+c) -: 8], row-major, MSB first.
- **Compaction:** packed byte k (k = 0..N*N-1) is element (k/N, k%N).
  - Byte k goes to word k/4, bits [31-8*(k%4) -: 8].
  - Bytes past N*N-1 in the last word are 0.
  - Elements outside the NxN block are discarded.
- **Word count W:** 1 (2x2), 3 (3x3), 4 (4x4), 7 (5x5).
- **Capture:** on load in IDLE, the compacted 7-word vector and W are registered. matrix_in and size are not used after that edge.
- **FSM states:** IDLE, SEND, DONE.
  - IDLE -> SEND on load.
  - SEND: a word transfers when out_valid && out_ready. The word counter increments on each transfer.
  - SEND -> DONE on transfer of word W-1.
  - DONE: done=1 for that cycle only, then -> IDLE unconditionally.
- **Handshake rules:**
  - out_valid=1 throughout SEND.
  - out_data, out_index and out_last stay stable while out_valid && !out_ready.
  - out_ready is ignored outside SEND.
- **Output values:**
  - out_data = stored word[out_index] in SEND, else 0.
  - out_last = (out_index == W-1) && out_valid.
- **Boundaries:**
  - load in SEND or DONE is ignored; captured data is not disturbed.
  - Simultaneous load and final transfer: load is ignored.
  - rst_n low at any time, including mid-stream: state -> IDLE, counter -> 0, stored words -> 0, all outputs -> 0 immediately. The partial stream is abandoned and done is not pulsed.
  - The 2x2 case (W=1) asserts out_last on the first and only word.

## Timing
- **Reset values:** out_valid=0, out_data=0, out_last=0, out_index=0, busy=0, done=0.
- **Start:** load high at edge T -> out_valid=1 and word 0 visible after T, with busy=1.
- **Continuous ready:** word i transfers at edge T+1+i. The last transfer is at edge T+W.
  - done=1 and out_valid=0 in the cycle after T+W.
  - IDLE, busy=0 after edge T+W+1.
  - The next load is accepted at edge T+W+2 at the earliest.
- **Backpressure:** each cycle with out_ready=0 in SEND delays all later events by one cycle. There is no word loss or duplication.
- **Throughput:** maximum one word per cycle; no bubbles between words within a matrix.

## Test plan
- **5x5:** matrix_in elements (r,c) = 5r+c+1 (0x01..0x19), size=11, out_ready=1.
  - Words: 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10, 0x11121314, 0x15161718, 0x19000000.
  - out_last on word 6; done one cycle later.
- **3x3:** elements (r,c) = 0x10*r+c, unused elements forced 0xFF, size=01.
  - Words: 0x00010210, 0x11122021, 0x22000000; no 0xFF bytes appear.
- **2x2 and 4x4:** same fill as the 3x3 case.
  - 2x2 -> single word 0x00011011 with out_last=1.
  - 4x4 -> 0x00010203, 0x10111213, 0x20212223, 0x30313233.
- **Backpressure:** 5x5 case with out_ready toggled pseudo-randomly.
  - out_data, out_index and out_last hold while stalled.
  - Exactly 7 transfers with the expected values; done once.
- **Load while busy:** during SEND, pulse load with a different matrix and size.
  - Stream continues with the original data and W; the new load is ignored.
- **Reset mid-stream:** assert rst_n=0 after word 2 of a 5x5 transfer.
  - All outputs 0 immediately; no done pulse.
  - After release, a fresh 2x2 load produces the correct single word.
